// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main memory between instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                busy,
  output logic                owner_d
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              mem_req_n, mem_we_n, busy_n, owner_d_n;
  logic [BE_W-1:0]   mem_be_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              if_rvalid_n, if_err_n, d_rvalid_n, d_err_n;
  logic [DATA_W-1:0] if_rdata_n, d_rdata_n;
  logic              grant_d_c, resp_c, resp_err_c;
  logic [DATA_W-1:0] resp_data_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Pointer set means data is favoured on the next contended grant.
  logic rr_d, rr_d_n;
  assign grant_d_c = d_req && (!if_req || rr_d);
`else
  assign grant_d_c = d_req;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_be_n    = mem_be;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    owner_d_n   = owner_d;
    if_rvalid_n = 1'b0;
    if_err_n    = 1'b0;
    if_rdata_n  = if_rdata;
    d_rvalid_n  = 1'b0;
    d_err_n     = 1'b0;
    d_rdata_n   = d_rdata;
    resp_c      = 1'b0;
    resp_err_c  = 1'b0;
    resp_data_c = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d_n      = rr_d;
`endif

    case (state)
      IDLE: begin
        if (d_req || if_req) begin
          state_n   = BUSY;
          cnt_n     = '0;
          mem_req_n = 1'b1;
          owner_d_n = grant_d_c;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_d_n    = !grant_d_c;
`endif
          if (grant_d_c) begin
            mem_we_n    = d_we;
            mem_be_n    = d_be;
            mem_addr_n  = d_addr;
            mem_wdata_n = d_wdata;
          end else begin
            mem_we_n    = 1'b0;
            mem_be_n    = '1;
            mem_addr_n  = if_addr;
            mem_wdata_n = '0;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          mem_req_n   = 1'b0;
          state_n     = RESP;
          resp_c      = 1'b1;
          resp_data_c = mem_we ? '0 : mem_rdata;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          mem_req_n  = 1'b0;
          state_n    = RESP;
          resp_c     = 1'b1;
          resp_err_c = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase

    // Response is steered to the owner; the other side stays quiet.
    if (resp_c) begin
      if (owner_d) begin
        d_rvalid_n = 1'b1;
        d_rdata_n  = resp_data_c;
        d_err_n    = resp_err_c;
      end else begin
        if_rvalid_n = 1'b1;
        if_rdata_n  = resp_data_c;
        if_err_n    = resp_err_c;
      end
    end

    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner_d   <= 1'b0;
      busy      <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_d      <= 1'b1;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_be    <= mem_be_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      owner_d   <= owner_d_n;
      busy      <= busy_n;
      if_rvalid <= if_rvalid_n;
      if_rdata  <= if_rdata_n;
      if_err    <= if_err_n;
      d_rvalid  <= d_rvalid_n;
      d_rdata   <= d_rdata_n;
      d_err     <= d_err_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_d      <= rr_d_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory accesses and responses are
// queued by the stimulus and checked by independent monitors.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we, mem_ack, busy, owner_d;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  bit ack_en = 1'b1;
  int ack_wait = 0;
  int req_cyc = 0;
  bit ignore_mem = 1'b0;
  int mcnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { bit is_d; logic [31:0] rdata; bit err; } resp_t;
  typedef struct { bit we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; int cycles; } mem_t;
  resp_t rq[$];
  mem_t  mq[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .owner_d(owner_d)
  );

  always #5 clock = ~clock;

  // Memory model: combinational ack after ack_wait extra request cycles.
  always @(posedge clock) req_cyc <= mem_req ? req_cyc + 1 : 0;
  assign mem_ack   = ack_en && mem_req && (req_cyc == ack_wait);
  assign mem_rdata = (mem_addr == 32'h10) ? 32'h00A00093 : {mem_addr[15:0], 16'hC0DE};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Response monitor.
  always @(negedge clock) begin
    if (if_rvalid || d_rvalid) begin
      check("rvalid_onehot", 32'(if_rvalid & d_rvalid), 32'd0);
      if (rq.size() == 0) begin
        check("unexpected_resp", 32'(1), 32'(0));
      end else begin
        resp_t e;
        e = rq.pop_front();
        check("resp_owner", 32'(d_rvalid), 32'(e.is_d));
        check("resp_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
        check("resp_err", 32'(e.is_d ? d_err : if_err), 32'(e.err));
      end
    end
  end

  // Memory-side monitor: fields held for the whole access, access length checked at its end.
  always @(negedge clock) begin
    if (ignore_mem) begin
      mcnt = 0;
    end else if (mem_req) begin
      if (mq.size() == 0) begin
        check("unexpected_mem_req", 32'(1), 32'(0));
      end else begin
        check("mem_we", 32'(mem_we), 32'(mq[0].we));
        check("mem_be", 32'(mem_be), 32'(mq[0].be));
        check("mem_addr", mem_addr, mq[0].addr);
        if (mq[0].we) check("mem_wdata", mem_wdata, mq[0].wdata);
      end
      mcnt++;
    end else if (mcnt > 0) begin
      if (mq.size() != 0) begin
        check("mem_req_cycles", 32'(mcnt), 32'(mq[0].cycles));
        void'(mq.pop_front());
      end
      mcnt = 0;
    end
  end

  task automatic fetch_txn(input logic [31:0] addr, output int lat);
    if_addr = addr;
    if_req  = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!if_rvalid && lat < 100);
    if (!if_rvalid) check("fetch_wait_expired", 32'(0), 32'(1));
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
    int n;
    d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    d_req = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!d_rvalid && n < 100);
    if (!d_rvalid) check("data_wait_expired", 32'(0), 32'(1));
    d_req = 1'b0;
  endtask

  function automatic void exp_mem(input bit we, input logic [3:0] be, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int cycles);
    mem_t m;
    m.we = we; m.be = be; m.addr = addr; m.wdata = wdata; m.cycles = cycles;
    mq.push_back(m);
  endfunction

  function automatic void exp_resp(input bit is_d, input logic [31:0] rdata, input bit err);
    resp_t r;
    r.is_d = is_d; r.rdata = rdata; r.err = err;
    rq.push_back(r);
  endfunction

  initial begin
    int lat, lat2, w;
    repeat (2) @(posedge clock);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_owner_d", 32'(owner_d), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Single zero-wait fetch.
    exp_mem(1'b0, 4'hF, 32'h10, 32'h0, 1);
    exp_resp(1'b0, 32'h00A00093, 1'b0);
    fetch_txn(32'h10, lat);
    check("fetch_latency", 32'(lat), 32'd2);

    // Contention: both requests together, data re-requests right after its first response.
    exp_mem(1'b0, 4'hF, 32'h40, 32'h0, 1);
    exp_resp(1'b1, 32'h0040C0DE, 1'b0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_mem(1'b0, 4'hF, 32'h20, 32'h0, 1);
    exp_resp(1'b0, 32'h0020C0DE, 1'b0);
    exp_mem(1'b0, 4'hF, 32'h44, 32'h0, 1);
    exp_resp(1'b1, 32'h0044C0DE, 1'b0);
`else
    exp_mem(1'b0, 4'hF, 32'h44, 32'h0, 1);
    exp_resp(1'b1, 32'h0044C0DE, 1'b0);
    exp_mem(1'b0, 4'hF, 32'h20, 32'h0, 1);
    exp_resp(1'b0, 32'h0020C0DE, 1'b0);
`endif
    fork
      fetch_txn(32'h20, lat2);
      begin
        data_txn(1'b0, 4'hF, 32'h40, 32'h0);
        data_txn(1'b0, 4'hF, 32'h44, 32'h0);
      end
    join

    // Store with two wait states: three request cycles, rdata returned as zero.
    ack_wait = 2;
    exp_mem(1'b1, 4'h3, 32'h100, 32'hDEADBEEF, 3);
    exp_resp(1'b1, 32'h0, 1'b0);
    data_txn(1'b1, 4'h3, 32'h100, 32'hDEADBEEF);
    ack_wait = 0;

    // Timeout on a load.
    ack_en = 1'b0;
    exp_mem(1'b0, 4'hF, 32'h200, 32'h0, 4);
    exp_resp(1'b1, 32'h0, 1'b1);
    data_txn(1'b0, 4'hF, 32'h200, 32'h0);
    @(posedge clock); #1;
    check("busy_after_timeout", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of an access.
    ignore_mem = 1'b1;
    if_addr = 32'h300;
    if_req  = 1'b1;
    w = 0;
    while (!mem_req && w < 20) begin
      @(posedge clock); #1;
      w++;
    end
    check("rst_test_mem_req_seen", 32'(mem_req), 32'd1);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rvalid", 32'(if_rvalid | d_rvalid), 32'd0);
    if_req = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(posedge clock);
    #1 ignore_mem = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd0);

    // Fresh fetch after reset.
    exp_mem(1'b0, 4'hF, 32'h30, 32'h0, 1);
    exp_resp(1'b0, 32'h0030C0DE, 1'b0);
    fetch_txn(32'h30, lat);
    check("post_rst_fetch_latency", 32'(lat), 32'd2);
    check("post_rst_owner_d", 32'(owner_d), 32'd0);

    repeat (3) @(posedge clock);
    #1;
    check("resp_queue_drained", 32'(rq.size()), 32'd0);
    check("mem_queue_drained", 32'(mq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between the instruction-fetch path (read-only) and the load/store path (read/write).
- Grants one requester at a time and holds memory signals for the whole transaction.
- Returns read data, or an error on timeout, through a registered one-cycle response pulse.
- Sits between the core datapath and the main_memory instance in top.

Parameters:
- ADDR_W, 32, byte-address width of all address ports.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- TIMEOUT_CYC, 64, BUSY cycles without mem_ack before aborting with error; legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_rvalid.
- if_addr  in  ADDR_W  fetch address.
- if_rvalid  out  1  one-cycle fetch response pulse.
- if_rdata  out  DATA_W  fetch data; valid while if_rvalid=1.
- if_err  out  1  fetch timed out; qualified by if_rvalid.
- d_req  in  1  data request; held with d_we, d_be, d_addr and d_wdata until d_rvalid.
- d_we  in  1  1=store, 0=load.
- d_be  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rvalid  out  1  one-cycle data response pulse.
- d_rdata  out  DATA_W  load data; 0 for stores.
- d_err  out  1  data access timed out; qualified by d_rvalid.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completes the access this cycle; may be combinational, i.e. in the first mem_req cycle.
- busy  out  1  state is not IDLE.
- owner_d  out  1  current or last grant: 1=data, 0=fetch.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including mem_req, which drops immediately.
  - The timeout counter clears and the round-robin pointer is set to favour data.
  - Any in-flight access is abandoned with no response pulse.
- All outputs are registered; there are no combinational input-to-output paths.
- States are IDLE, BUSY and RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner. Default is fixed priority, so d_req beats if_req.
  - Latch the winner's addr/we/be/wdata into the mem_* registers; a fetch drives mem_we=0 and mem_be=all ones.
  - Set owner_d and go to BUSY; mem_req=1 from the next cycle.
- BUSY:
  - mem_req and the mem_* outputs are held constant.
  - If mem_ack=1: capture mem_rdata (store gives 0), clear mem_req and go to RESP with err=0.
  - Else if the timeout counter equals TIMEOUT_CYC-1: clear mem_req, rdata=0, go to RESP with err=1.
  - Else increment the counter.
- RESP:
  - Exactly one cycle: the owner's *_rvalid=1, with its *_rdata and *_err driven.
  - The other requester's outputs stay 0.
  - Go to IDLE, clearing rvalid and the counter.
  - Requests are ignored in RESP. A requester may drop its request or present the next one in the rvalid cycle.
- Latency: request seen at edge N, mem_req high from N to N+1, zero-wait ack gives rvalid in cycle N+2, and the next grant is possible at edge N+3.
- A request arriving during BUSY/RESP waits, with its inputs held, until IDLE.
- Both requests asserted in the same IDLE cycle resolve by the priority rule; the loser is served in the next IDLE.
- mem_ack outside BUSY is ignored.
- A requester dropping its request mid-transaction is illegal; the transaction still completes and the response is still pulsed.
- *_rdata holds its value after the pulse until the next response for that requester.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit pointer selects the requester that was NOT granted last whenever both are pending in IDLE. The pointer updates on each grant.
- Undefined: fixed priority, data over fetch, and no pointer register.
- A single requester is granted immediately in both modes.

Test Plan:
- Single fetch: if_req=1, if_addr=0x00000010, ack on first mem_req cycle with mem_rdata=0x00A00093 -> mem_req high for exactly 1 cycle with mem_we=0, mem_be=0xF; if_rvalid pulses 1 cycle 2 cycles after the request edge with if_rdata=0x00A00093, if_err=0.
- Store with wait states: d_req=1, d_we=1, d_be=0x3, d_addr=0x100, d_wdata=0xDEADBEEF, ack after 3 cycles -> mem_addr/mem_wdata/mem_be stable across all 3 mem_req cycles; d_rvalid=1 with d_rdata=0, d_err=0; if_rvalid stays 0.
- Contention: if_req and d_req asserted in the same cycle, both held -> macro off: data served first, then fetch. Macro on: requests are served alternately (first data, then fetch) when both are re-requested continuously.
- Timeout: d_req load with mem_ack tied 0, TIMEOUT_CYC=4 -> mem_req high exactly 4 cycles; d_rvalid=1, d_err=1, d_rdata=0; arbiter then returns to IDLE (busy=0).
- Reset mid-access: reset=0 while in BUSY, asynchronously between edges -> mem_req, busy and all rvalid go to 0 before the next edge. No response pulse after release. A fresh if_req is then granted normally.
